// File: rtl/dma_sched_pkg.sv
// Shared definitions for the two-channel DMA descriptor scheduler.
// State encodings are fixed because external tooling decodes them.
package dma_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned NUM_CH = 2;

endpackage

// File: rtl/dma_sched_rr_arb.sv
// Two-way round-robin arbiter: on a tie the channel not served last wins.
module dma_rr_arb
    import dma_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic              last_grant,
    input  logic              enable,
    output logic              winner,
    output logic              valid
);

    always_comb begin
        valid  = enable & (|req);
        winner = (req == '1) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/dma_sched.sv
// Round-robin descriptor scheduler in front of the single dma_transfer engine;
// latches the winning descriptor and steers engine streams to the granted channel.
module dma_sched
    import dma_sched_pkg::*;
#(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ch0_desc_valid,
    output logic                  ch0_desc_ready,
    input  logic [AXI_ADDR_W-1:0] ch0_addr,
    input  logic [LEN_W-1:0]      ch0_len,
    input  logic                  ch0_rnw,
    output logic                  ch0_done,
    input  logic [DATA_W-1:0]     ch0_data_in,
    output logic                  ch0_ready_in,
    output logic [DATA_W-1:0]     ch0_data_out,
    output logic                  ch0_valid_out,

    input  logic                  ch1_desc_valid,
    output logic                  ch1_desc_ready,
    input  logic [AXI_ADDR_W-1:0] ch1_addr,
    input  logic [LEN_W-1:0]      ch1_len,
    input  logic                  ch1_rnw,
    output logic                  ch1_done,
    input  logic [DATA_W-1:0]     ch1_data_in,
    output logic                  ch1_ready_in,
    output logic [DATA_W-1:0]     ch1_data_out,
    output logic                  ch1_valid_out,

    output logic [AXI_ADDR_W-1:0] dma_addr,
    output logic [LEN_W-1:0]      dma_length,
    output logic                  dma_rnw,
    output logic                  dma_start,
    input  logic                  dma_ready,
    output logic [DATA_W-1:0]     dma_data_in,
    input  logic                  dma_ready_in,
    input  logic [DATA_W-1:0]     dma_data_out,
    input  logic                  dma_valid_out,

    output logic                  busy,
    output logic                  grant
);

    state_t                state, state_nxt;
    logic                  grant_q;
    logic                  last_grant;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]      len_q;
    logic                  rnw_q;

    logic                  arb_en;
    logic                  arb_winner;
    logic                  arb_valid;
    logic [LEN_W-1:0]      win_len;

    // An engine still busy from a reset race blocks acceptance.
    assign arb_en  = (state == ST_IDLE) && dma_ready;
    assign win_len = arb_winner ? ch1_len : ch0_len;

    dma_rr_arb u_arb (
        .req        ({ch1_desc_valid, ch0_desc_valid}),
        .last_grant (last_grant),
        .enable     (arb_en),
        .winner     (arb_winner),
        .valid      (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            len_q      <= '0;
            rnw_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (arb_valid) begin
                grant_q <= arb_winner;
                addr_q  <= arb_winner ? ch1_addr : ch0_addr;
                len_q   <= win_len;
                rnw_q   <= arb_winner ? ch1_rnw : ch0_rnw;
            end
            if (state == ST_DONE)
                last_grant <= grant_q;
        end
    end

    always_comb begin
        state_nxt      = state;
        dma_start      = 1'b0;
        ch0_done       = 1'b0;
        ch1_done       = 1'b0;
        ch0_desc_ready = 1'b0;
        ch1_desc_ready = 1'b0;
        busy           = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                ch0_desc_ready = arb_valid & ~arb_winner;
                ch1_desc_ready = arb_valid &  arb_winner;
                if (arb_valid)
                    state_nxt = (win_len != '0) ? ST_START : ST_DONE;
            end
            ST_START: begin
                dma_start = 1'b1;
                state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (dma_ready)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ch0_done  = ~grant_q;
                ch1_done  =  grant_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign dma_addr   = addr_q;
    assign dma_length = len_q;
    assign dma_rnw    = rnw_q;
    assign grant      = grant_q;

    // Steering stays on the latched grant in IDLE so the engine's trailing word lands correctly.
    assign dma_data_in   = grant_q ? ch1_data_in : ch0_data_in;
    assign ch0_ready_in  = dma_ready_in & ~grant_q;
    assign ch1_ready_in  = dma_ready_in &  grant_q;
    assign ch0_data_out  = dma_data_out;
    assign ch1_data_out  = dma_data_out;
    assign ch0_valid_out = dma_valid_out & ~grant_q;
    assign ch1_valid_out = dma_valid_out &  grant_q;

endmodule

// File: tb/tb_dma_sched.sv
// Directed-vector bench for dma_sched; the bench itself plays the DMA engine.
module tb_dma_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        ch0_desc_valid, ch1_desc_valid;
    logic        ch0_desc_ready, ch1_desc_ready;
    logic [31:0] ch0_addr, ch1_addr;
    logic [15:0] ch0_len, ch1_len;
    logic        ch0_rnw, ch1_rnw;
    logic        ch0_done, ch1_done;
    logic [31:0] ch0_data_in, ch1_data_in;
    logic        ch0_ready_in, ch1_ready_in;
    logic [31:0] ch0_data_out, ch1_data_out;
    logic        ch0_valid_out, ch1_valid_out;
    logic [31:0] dma_addr;
    logic [15:0] dma_length;
    logic        dma_rnw, dma_start, dma_ready;
    logic [31:0] dma_data_in;
    logic        dma_ready_in;
    logic [31:0] dma_data_out;
    logic        dma_valid_out;
    logic        busy, grant;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dma_sched #(.AXI_ADDR_W(32), .LEN_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ch0_desc_valid(ch0_desc_valid), .ch0_desc_ready(ch0_desc_ready),
        .ch0_addr(ch0_addr), .ch0_len(ch0_len), .ch0_rnw(ch0_rnw), .ch0_done(ch0_done),
        .ch0_data_in(ch0_data_in), .ch0_ready_in(ch0_ready_in),
        .ch0_data_out(ch0_data_out), .ch0_valid_out(ch0_valid_out),
        .ch1_desc_valid(ch1_desc_valid), .ch1_desc_ready(ch1_desc_ready),
        .ch1_addr(ch1_addr), .ch1_len(ch1_len), .ch1_rnw(ch1_rnw), .ch1_done(ch1_done),
        .ch1_data_in(ch1_data_in), .ch1_ready_in(ch1_ready_in),
        .ch1_data_out(ch1_data_out), .ch1_valid_out(ch1_valid_out),
        .dma_addr(dma_addr), .dma_length(dma_length), .dma_rnw(dma_rnw),
        .dma_start(dma_start), .dma_ready(dma_ready),
        .dma_data_in(dma_data_in), .dma_ready_in(dma_ready_in),
        .dma_data_out(dma_data_out), .dma_valid_out(dma_valid_out),
        .busy(busy), .grant(grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int ch, input logic [31:0] a, input logic [15:0] l, input logic r);
        if (ch == 0) begin
            ch0_desc_valid = 1'b1; ch0_addr = a; ch0_len = l; ch0_rnw = r;
        end else begin
            ch1_desc_valid = 1'b1; ch1_addr = a; ch1_len = l; ch1_rnw = r;
        end
    endtask

    // Runs one transfer from IDLE (descriptor already offered) back to IDLE.
    task automatic do_xfer(input int ch, input logic [31:0] a, input logic [15:0] l,
                           input logic r, input int busy_cyc, input logic drop_valid);
        logic [1:0] one_hot;
        one_hot = (ch == 0) ? 2'b01 : 2'b10;
        #1;
        chk("desc_ready", {ch1_desc_ready, ch0_desc_ready}, one_hot);
        step();
        if (drop_valid) begin
            if (ch == 0) ch0_desc_valid = 1'b0; else ch1_desc_valid = 1'b0;
        end
        #1;
        chk("desc_ready_off", {ch1_desc_ready, ch0_desc_ready}, 2'b00);
        chk("grant", grant, ch[0]);
        chk("busy", busy, 1'b1);
        if (l == 16'd0) begin
            chk("zl_done", {ch1_done, ch0_done}, one_hot);
            chk("zl_start", dma_start, 1'b0);
            step();
            chk("zl_done_clr", {ch1_done, ch0_done}, 2'b00);
            chk("zl_start_idle", dma_start, 1'b0);
            chk("zl_busy", busy, 1'b0);
            return;
        end
        chk("start", dma_start, 1'b1);
        chk("cfg", {dma_addr, dma_length, dma_rnw}, {a, l, r});
        chk("done_start", {ch1_done, ch0_done}, 2'b00);
        step();
        dma_ready = 1'b0;
        for (int i = 0; i < busy_cyc; i++) begin
            if (i == busy_cyc - 1) dma_ready = 1'b1;
            ch0_data_in   = 32'hA000_0000 | i;
            ch1_data_in   = 32'hB000_0000 | i;
            dma_data_out  = 32'hC000_0000 | i;
            dma_ready_in  = i[0];
            dma_valid_out = i[1];
            #1;
            chk("busy_start", dma_start, 1'b0);
            chk("busy_done", {ch1_done, ch0_done}, 2'b00);
            chk("busy_cfg", {dma_addr, dma_length, dma_rnw}, {a, l, r});
            chk("data_in", dma_data_in, (ch == 0) ? (32'hA000_0000 | i) : (32'hB000_0000 | i));
            chk("ready_in", {ch1_ready_in, ch0_ready_in}, i[0] ? one_hot : 2'b00);
            chk("valid_out", {ch1_valid_out, ch0_valid_out}, i[1] ? one_hot : 2'b00);
            chk("data_out", {ch1_data_out, ch0_data_out}, {2{32'hC000_0000 | i}});
            step();
        end
        dma_ready_in  = 1'b0;
        dma_valid_out = 1'b0;
        #1;
        chk("done", {ch1_done, ch0_done}, one_hot);
        chk("done_start", dma_start, 1'b0);
        chk("done_cfg", {dma_addr, dma_length, dma_rnw}, {a, l, r});
        step();
        dma_valid_out = 1'b1;
        #1;
        chk("trail_valid", {ch1_valid_out, ch0_valid_out}, one_hot);
        chk("idle_done", {ch1_done, ch0_done}, 2'b00);
        chk("idle_busy", busy, 1'b0);
        dma_valid_out = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        ch0_desc_valid = 1'b0; ch1_desc_valid = 1'b0;
        ch0_addr = '0; ch1_addr = '0; ch0_len = '0; ch1_len = '0;
        ch0_rnw = 1'b0; ch1_rnw = 1'b0;
        ch0_data_in = '0; ch1_data_in = '0;
        dma_ready = 1'b1; dma_ready_in = 1'b0; dma_data_out = '0; dma_valid_out = 1'b0;
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_start", dma_start, 1'b0);
        chk("rst_done", {ch1_done, ch0_done}, 2'b00);
        chk("rst_ready", {ch1_desc_ready, ch0_desc_ready}, 2'b00);
        chk("rst_cfg", {dma_addr, dma_length, dma_rnw}, 49'd0);
        rst = 1'b1;
        step();

        // Single read on ch0; the final trailing word must reach ch0 only.
        offer(0, 32'h100, 16'd8, 1'b1);
        do_xfer(0, 32'h100, 16'd8, 1'b1, 3, 1'b1);

        // Both channels continuously valid: ch0 was last, so ch1 leads.
        offer(0, 32'h400, 16'd4, 1'b1);
        offer(1, 32'h800, 16'd4, 1'b0);
        do_xfer(1, 32'h800, 16'd4, 1'b0, 2, 1'b0);
        do_xfer(0, 32'h400, 16'd4, 1'b1, 2, 1'b0);
        do_xfer(1, 32'h800, 16'd4, 1'b0, 2, 1'b0);
        do_xfer(0, 32'h400, 16'd4, 1'b1, 2, 1'b1);
        ch1_desc_valid = 1'b0;
        step();

        // Zero-length descriptor on ch1.
        offer(1, 32'h300, 16'd0, 1'b1);
        do_xfer(1, 32'h300, 16'd0, 1'b1, 1, 1'b1);

        // ch1 write, 13 bytes at an unaligned address.
        offer(1, 32'h203, 16'd13, 1'b0);
        do_xfer(1, 32'h203, 16'd13, 1'b0, 5, 1'b1);

        // Engine not ready in IDLE blocks acceptance.
        dma_ready = 1'b0;
        offer(0, 32'h500, 16'd4, 1'b1);
        #1;
        chk("blocked_ready", {ch1_desc_ready, ch0_desc_ready}, 2'b00);
        step();
        chk("blocked_busy", busy, 1'b0);
        dma_ready = 1'b1;
        do_xfer(0, 32'h500, 16'd4, 1'b1, 2, 1'b1);

        // Reset during BUSY.
        offer(1, 32'h600, 16'd16, 1'b1);
        #1;
        chk("pre_rst_ready", {ch1_desc_ready, ch0_desc_ready}, 2'b10);
        step();
        ch1_desc_valid = 1'b0;
        step();
        dma_ready = 1'b0;
        step();
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b0;
        step();
        dma_ready = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_start", dma_start, 1'b0);
        chk("mid_rst_done", {ch1_done, ch0_done}, 2'b00);
        chk("mid_rst_cfg", {dma_addr, dma_length, dma_rnw}, 49'd0);
        rst = 1'b1;
        step();
        chk("post_rst_done", {ch1_done, ch0_done}, 2'b00);

        // After reset ch0 wins the first tie.
        offer(0, 32'h700, 16'd4, 1'b1);
        offer(1, 32'h780, 16'd4, 1'b1);
        do_xfer(0, 32'h700, 16'd4, 1'b1, 2, 1'b1);
        do_xfer(1, 32'h780, 16'd4, 1'b1, 2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
